// File: rtl/loong_dec.sv
// LOONG block decryptor: iterative core, one inverse sub-step per clock.
// A block takes 81 clocks from the start edge to the o_done pulse.
module loong_dec #(
  parameter int ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_do_dec,
  input  logic [63:0] i_ciphertext,
  input  logic [63:0] i_roundKey,
  output logic [63:0] o_plaintext,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {IDLE, INIT, ISUB1, IMIXC, IMIXR, ISUB2, ARK} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  round_reg, round_next;
  logic [63:0] s_reg, s_next;
  logic [63:0] key_reg, key_next;
  logic [63:0] pt_reg, pt_next;
  logic        done_reg, done_next;
  logic [63:0] ark_val;

  // Inverse of the shared 4-bit S-box C56B90AD3EF84712.
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_sub_cells(input logic [63:0] s);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(s[4*n +: 4]);
    return y;
  endfunction

  // Row mixing (each nibble becomes the XOR of the other three in its row)
  // is an involution over GF(2), so its inverse has the same form.
  function automatic logic [63:0] inv_mix_row(input logic [63:0] s);
    logic [63:0] y;
    logic [3:0]  x0, x1, x2, x3;
    for (int r = 0; r < 4; r++) begin
      x0 = s[16*r +: 4];
      x1 = s[16*r + 4 +: 4];
      x2 = s[16*r + 8 +: 4];
      x3 = s[16*r + 12 +: 4];
      y[16*r +: 4]      = x1 ^ x2 ^ x3;
      y[16*r + 4 +: 4]  = x0 ^ x2 ^ x3;
      y[16*r + 8 +: 4]  = x0 ^ x1 ^ x3;
      y[16*r + 12 +: 4] = x0 ^ x1 ^ x2;
    end
    return y;
  endfunction

  // Column mixing is a chain of XOR lifting steps (a^=b, b^=d, d^=e, e^=a);
  // undoing it replays the steps in reverse order.
  function automatic logic [63:0] inv_mix_column(input logic [63:0] s);
    logic [63:0] y;
    logic [3:0]  a, b, d, e;
    for (int c = 0; c < 4; c++) begin
      a = s[4*c +: 4];
      b = s[4*(c+4) +: 4];
      d = s[4*(c+8) +: 4];
      e = s[4*(c+12) +: 4];
      e = e ^ a;
      d = d ^ e;
      b = b ^ d;
      a = a ^ b;
      y[4*c +: 4]      = a;
      y[4*(c+4) +: 4]  = b;
      y[4*(c+8) +: 4]  = d;
      y[4*(c+12) +: 4] = e;
    end
    return y;
  endfunction

  // Shared round constant: nibble n = n ^ r[3:0] ^ {r[4],3'b000}.
  function automatic logic [63:0] rc(input logic [4:0] r);
    logic [63:0] v;
    for (int n = 0; n < 16; n++) v[4*n +: 4] = 4'(n) ^ r[3:0] ^ {r[4], 3'b000};
    return v;
  endfunction

  assign ark_val = s_reg ^ key_reg ^ rc(round_reg - 5'd1);

  // Next-state and datapath: one operator applied to the state per FSM step.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    s_next     = s_reg;
    key_next   = key_reg;
    pt_next    = pt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_do_dec) begin
          s_next     = i_ciphertext;
          key_next   = i_roundKey;
          state_next = INIT;
        end
      end
      INIT: begin
        s_next     = s_reg ^ key_reg ^ rc(5'(ROUNDS));
        round_next = 5'(ROUNDS);
        state_next = ISUB1;
      end
      ISUB1: begin
        s_next     = inv_sub_cells(s_reg);
        state_next = IMIXC;
      end
      IMIXC: begin
        s_next     = inv_mix_column(s_reg);
        state_next = IMIXR;
      end
      IMIXR: begin
        s_next     = inv_mix_row(s_reg);
        state_next = ISUB2;
      end
      ISUB2: begin
        s_next     = inv_sub_cells(s_reg);
        state_next = ARK;
      end
      ARK: begin
        s_next     = ark_val;
        round_next = round_reg - 5'd1;
        if (round_reg == 5'd1) begin
          pt_next    = ark_val;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ISUB1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      round_reg <= 5'd0;
      s_reg     <= 64'd0;
      key_reg   <= 64'd0;
      pt_reg    <= 64'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      s_reg     <= s_next;
      key_reg   <= key_next;
      pt_reg    <= pt_next;
      done_reg  <= done_next;
    end
  end

  assign o_plaintext = pt_reg;
  assign o_busy      = (state_reg != IDLE);
  assign o_done      = done_reg;

endmodule
